// File: rtl/lutram_bist_ctrl_if.sv
// Signal bundle between the LUTRAM BIST sequencer (master) and the
// board status logic plus the array port (slave).
interface lutram_bist_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdat;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdat;

    modport master (
        input  start, ram_rdat,
        output busy, done, pass, err_cnt, fail_addr, ram_addr, ram_wdat, ram_we
    );

    modport slave (
        output start, ram_rdat,
        input  busy, done, pass, err_cnt, fail_addr, ram_addr, ram_wdat, ram_we
    );
endinterface

// File: rtl/lutram_bist_ctrl.sv
// Write/read-back/compare self-test sequencer for the LUTRAM array.
// Define LUTRAM_BIST_INVERT_PASS_EN to add a second pass with inverted data.
module lutram_bist_ctrl #(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 10,
    parameter logic [DATA_W-1:0] SEED   = 10'h0BC,
    parameter int                RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    lutram_bist_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam int                DRN_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DRN_W-1:0]  drn_cnt, drn_nxt;
    logic              inv, inv_nxt;
    logic              last_addr, pass_end, start_acc, fin_entry;

    logic              busy_q, done_q, pass_q, ram_we_q;
    logic [7:0]        err_q, err_nxt;
    logic [ADDR_W-1:0] fail_q;
    logic [DATA_W-1:0] ram_wdat_q;

    logic              cmp_vld, mismatch;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic flip);
        logic [DATA_W-1:0] p;
        p = '0;
        p[2*ADDR_W-1:0] = {a, ~a};
        return p ^ SEED ^ {DATA_W{flip}};
    endfunction

    assign last_addr = (addr_q == ADDR_LAST);
    assign start_acc = ((state == IDLE) || (state == FIN)) && bus.start;
    assign pass_end  = ((state == RD) && last_addr && (RD_LAT == 0)) ||
                       ((state == DRAIN) && (drn_cnt == DRN_LAST));
    assign fin_entry = (state_nxt == FIN) && (state != FIN);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        drn_nxt   = '0;
`ifdef LUTRAM_BIST_INVERT_PASS_EN
        inv_nxt   = inv;
`endif
        unique case (state)
            IDLE, FIN: begin
                if (bus.start) begin
                    state_nxt = WR;
                    addr_nxt  = '0;
`ifdef LUTRAM_BIST_INVERT_PASS_EN
                    inv_nxt   = 1'b0;
`endif
                end
            end
            WR: begin
                // Address wraps to 0 on the last write, so reads start with no dead cycle.
                addr_nxt = addr_q + 1'b1;
                if (last_addr) state_nxt = RD;
            end
            RD: begin
                addr_nxt = addr_q + 1'b1;
                if (last_addr) state_nxt = DRAIN;
            end
            DRAIN: drn_nxt = drn_cnt + 1'b1;
        endcase

        if (pass_end) begin
            state_nxt = FIN;
`ifdef LUTRAM_BIST_INVERT_PASS_EN
            if (!inv) begin
                state_nxt = WR;
                inv_nxt   = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            drn_cnt <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            drn_cnt <= drn_nxt;
        end
    end

`ifdef LUTRAM_BIST_INVERT_PASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inv <= 1'b0;
        else     inv <= inv_nxt;
    end
`else
    assign inv     = 1'b0;
    assign inv_nxt = 1'b0;
`endif

    // Expected data and address travel alongside the read for RD_LAT clocks.
    generate
        if (RD_LAT == 0) begin : g_comb_read
            assign cmp_vld  = (state == RD);
            assign cmp_exp  = pattern(addr_q, inv);
            assign cmp_addr = addr_q;
        end else begin : g_reg_read
            logic [RD_LAT-1:0] vld_sr;
            logic [DATA_W-1:0] exp_sr  [RD_LAT];
            logic [ADDR_W-1:0] addr_sr [RD_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_sr <= '0;
                else begin
                    vld_sr[0] <= (state == RD);
                    for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
                end
            end

            // NOTE: payload stages carry no reset; the valid bit alone qualifies them.
            always_ff @(posedge clk) begin
                exp_sr[0]  <= pattern(addr_q, inv);
                addr_sr[0] <= addr_q;
                for (int i = 1; i < RD_LAT; i++) begin
                    exp_sr[i]  <= exp_sr[i-1];
                    addr_sr[i] <= addr_sr[i-1];
                end
            end

            assign cmp_vld  = vld_sr[RD_LAT-1];
            assign cmp_exp  = exp_sr[RD_LAT-1];
            assign cmp_addr = addr_sr[RD_LAT-1];
        end
    endgenerate

    always_comb begin
        mismatch = cmp_vld && (bus.ram_rdat != cmp_exp);
        err_nxt  = err_q;
        if (mismatch && (err_q != 8'hFF)) err_nxt = err_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_wdat_q <= '0;
            err_q      <= '0;
            fail_q     <= '0;
        end else begin
            busy_q   <= state_nxt inside {WR, RD, DRAIN};
            ram_we_q <= (state_nxt == WR);
            if (state_nxt == WR) ram_wdat_q <= pattern(addr_nxt, inv_nxt);

            if (start_acc) begin
                err_q  <= '0;
                fail_q <= '0;
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                err_q <= err_nxt;
                // A zero count means no earlier mismatch in this run.
                if (mismatch && (err_q == 8'd0)) fail_q <= cmp_addr;
                if (fin_entry) begin
                    done_q <= 1'b1;
                    pass_q <= (err_nxt == 8'd0);
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_q;
    assign bus.fail_addr = fail_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdat  = ram_wdat_q;
    assign bus.ram_we    = ram_we_q;
endmodule

// File: doc/lutram_bist_ctrl.md
# lutram_bist_ctrl

Built-in self-test sequencer for the LUTRAM stress-test array: it drives the array's `addr`/`wdat`/`we` port, writes a deterministic address-derived pattern to every entry, reads each entry back, and compares it. It reports busy/done/pass, an error count and the first failing address. It sits between the board-level start/status logic and the LUTRAM `top` instance, and replaces hand-driven bench stimulus on hardware.

## Interface
- `ADDR_W`, 5, array address width; depth = 2**ADDR_W (32 = two 16x10 LUTRAMs)
- `DATA_W`, 10, array data width; must be ≥ 2*ADDR_W
- `SEED`, 10'h0BC, XOR mask applied to the pattern (width DATA_W)
- `RD_LAT`, 1, array read latency in clocks (0 = combinational read, 1 = registered)

- `clk` in 1 — single clock for the block and the array
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — one-cycle request to run a test
- `busy` out 1 — test in progress
- `done` out 1 — test finished; held until next accepted `start`
- `pass` out 1 — valid when `done`=1; 1 = zero mismatches
- `err_cnt` out 8 — mismatch count of the current/last run
- `fail_addr` out ADDR_W — address of the first mismatch; 0 if none
- `ram_addr` out ADDR_W — array address
- `ram_wdat` out DATA_W — array write data
- `ram_we` out 1 — array write enable
- `ram_rdat` in DATA_W — array read data

## Operation
- Pattern: P(a) = ({a, ~a} zero-extended to DATA_W) XOR SEED. For defaults, P(0)=10'h01F^10'h0BC=10'h0A3.
- States:
  - IDLE: accept `start` and go to WR.
  - WR: `ram_we`=1, `ram_addr`=a, `ram_wdat`=P(a), with a=0..DEPTH-1 at one address per clock. After the last address, go to RD.
  - RD: `ram_we`=0, `ram_addr`=a with a=0..DEPTH-1 at one per clock. Each read is compared RD_LAT clocks after its address is issued. After the last address, go to DRAIN.
  - DRAIN: wait RD_LAT clocks so the final compares complete (0 clocks when RD_LAT=0), then go to FIN.
  - FIN: `done`=1 and `busy`=0. Accept `start` and go to WR.
- Compare pipeline: the expected value and the address are delayed RD_LAT stages alongside the read.
- On a mismatch:
  - `err_cnt` increments and saturates at 8'hFF.
  - `fail_addr` is captured only on the first mismatch of the run.
- Accepted `start`: clears `err_cnt`, `fail_addr`, `done` and `pass`.
- `start` asserted while `busy`: ignored and not queued.
- `pass` is registered as (`err_cnt`==0) on entry to FIN.
- Outside WR: `ram_wdat` holds the last written value and `ram_we`=0.

## Timing
- Reset values:
  - `busy`, `done`, `pass`, `ram_we` = 0
  - `err_cnt`, `fail_addr`, `ram_addr` = 0
  - `ram_wdat` = 0
  - state = IDLE
- `rst` mid-run: outputs take their reset values immediately (asynchronously). `ram_we` drops the same instant. Array contents are undefined afterwards, and no `done` is produced.
- `start` is sampled at edge T0. Then:
  - `busy`=1 and first write (addr 0) are present after T0.
  - Writes occupy cycles 1..DEPTH.
  - Reads occupy cycles DEPTH+1..2*DEPTH.
  - The last compare completes at cycle 2*DEPTH+RD_LAT.
  - `done` rises at cycle 2*DEPTH+RD_LAT+1.
  - Defaults: done 66 clocks after T0.
- There is no dead cycle between WR and RD. The address wraps DEPTH-1 → 0 at the phase change.
- All outputs are registered; there is no combinational path from `ram_rdat` to any output.

## Configuration
- `LUTRAM_BIST_INVERT_PASS_EN`, when defined:
  - After the first RD/DRAIN, run a second WR/RD/DRAIN with data ~P(a). Every bit then sees both polarities.
  - `err_cnt` and `fail_addr` accumulate across both passes.
  - `done` rises at cycle 4*DEPTH+2*RD_LAT+1.
- When undefined: single pass only, with no second-pass state or logic.

## Test plan
- Clean run with defaults and an ideal RAM model (RD_LAT=1), `start` at T0:
  - Write cycle 1 shows addr 0 / wdat 10'h0A3.
  - addr 5'h1F shows P(31)=10'h3E0^10'h0BC=10'h35C.
  - `done`=1, `pass`=1 and `err_cnt`=0 at T0+66.
- RAM model with bit 3 stuck-at-1:
  - Every address where P(a)[3]=0 miscompares.
  - `pass`=0, `err_cnt` equals that count, `fail_addr` = lowest such address.
- `start` pulsed on cycles 10 and 40 of a run: ignored. Exactly one `done` edge at T0+66, with results identical to the clean run.
- `rst` asserted on write cycle 12 for one cycle:
  - `ram_we`, `busy` and `err_cnt` are 0 immediately and `done` stays 0.
  - A new `start` then completes a clean pass.
- RD_LAT=0 build with a combinational-read model: `done` at T0+65, `pass`=1.
- Macro defined, stuck-bit model:
  - Both polarities fail, so `err_cnt`=32 over the two passes.
  - `done` at T0+131 (RD_LAT=1).
